// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target endpoint.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        IGNORE
    } state_t;

    // Cycles between rd_req and the cycle rd_data is captured.
    localparam int RD_SAMPLE_DLY    = 2;
    // Default glitch filter depth in CLOCK_50 samples.
    localparam int FILT_LEN_DEFAULT = 3;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchronizes one raw I2C pad line, rejects glitches shorter than FILT_LEN samples, flags edges.
// Latency: 2 + FILT_LEN cycles from pad change to filtered change and its rise/fall pulse.
// Backpressure: none; free-running sampler.
module i2c_line_filter import i2c_pkg::*; #(
    parameter int FILT_LEN = FILT_LEN_DEFAULT
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic line_i,
    output logic filt_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = $clog2(FILT_LEN + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          rise_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          flip_d;

    // Count consecutive samples that disagree with the filtered value; flip after FILT_LEN.
    always_comb begin
        cnt_d  = '0;
        flip_d = 1'b0;
        if (sync2_q != filt_q) begin
            if (cnt_q == CW'(FILT_LEN - 1)) begin
                flip_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, filtered level and edge pulses; idle bus level is high.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            rise_q  <= flip_d & sync2_q;
            fall_q  <= flip_d & ~sync2_q;
            if (flip_d) begin
                filt_q <= sync2_q;
            end
        end
    end

    assign filt_o = filt_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/i2c_target.sv
// Oversampled I2C target at one 7-bit address: write bytes out on a strobe, read bytes fetched by request.
// Latency: pad to internal edge 2+FILT_LEN cycles; SDA drive 1 cycle after the internal SCL fall; read MSB 3 cycles after it.
// Backpressure: none; no clock stretching, rd_data must be valid RD_SAMPLE_DLY cycles after rd_req.
module i2c_target import i2c_pkg::*; #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         FILT_LEN    = FILT_LEN_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       wr_valid,
    output logic [7:0] wr_data,
    output logic       wr_first,
    output logic       rd_req,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       addressed
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;
    logic start_det, stop_det;

    state_t     state_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic       sda_oe_q;
    logic       wr_valid_q;
    logic [7:0] wr_data_q;
    logic       wr_first_q;
    logic       first_arm_q;
    logic       rd_req_q;
    logic [1:0] rd_dly_q;
    logic       busy_q;
    logic       addressed_q;
    // ADDR_ACK: ACK already driven; RD_ACK: master ACK seen.
    logic       phase_q;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .line_i   (scl_in),
        .filt_o   (scl_f),
        .rise_o   (scl_rise),
        .fall_o   (scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .line_i   (sda_in),
        .filt_o   (sda_f),
        .rise_o   (sda_rise),
        .fall_o   (sda_fall)
    );

    // scl_f is already post-edge, so an SCL fall in the same cycle suppresses START/STOP.
    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;

    // Protocol FSM; START/STOP override every state. addressed survives a repeated START
    // and only drops on STOP or when the new address is not ours.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'h00;
            sda_oe_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_data_q   <= 8'h00;
            wr_first_q  <= 1'b0;
            first_arm_q <= 1'b0;
            rd_req_q    <= 1'b0;
            rd_dly_q    <= 2'd0;
            busy_q      <= 1'b0;
            addressed_q <= 1'b0;
            phase_q     <= 1'b0;
        end else begin
            wr_valid_q <= 1'b0;
            rd_req_q   <= 1'b0;
            if (rd_dly_q != 2'd0) begin
                rd_dly_q <= rd_dly_q - 1'b1;
            end
            if (start_det) begin
                state_q   <= ADDR;
                bit_cnt_q <= 4'd0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b1;
                phase_q   <= 1'b0;
                rd_dly_q  <= 2'd0;
            end else if (stop_det) begin
                state_q     <= IDLE;
                sda_oe_q    <= 1'b0;
                busy_q      <= 1'b0;
                addressed_q <= 1'b0;
                phase_q     <= 1'b0;
                rd_dly_q    <= 2'd0;
            end else begin
                case (state_q)
                    ADDR: begin
                        if (scl_rise) begin
                            shift_q <= {shift_q[6:0], sda_f};
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= 4'd0;
                                if (shift_q[6:0] == TARGET_ADDR) begin
                                    state_q <= ADDR_ACK;
                                end else begin
                                    state_q     <= IGNORE;
                                    addressed_q <= 1'b0;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (!phase_q) begin
                                sda_oe_q <= 1'b1;
                                phase_q  <= 1'b1;
                            end else begin
                                sda_oe_q    <= 1'b0;
                                phase_q     <= 1'b0;
                                addressed_q <= 1'b1;
                                if (shift_q[0]) begin
                                    state_q  <= RD_BYTE;
                                    rd_req_q <= 1'b1;
                                    rd_dly_q <= 2'(RD_SAMPLE_DLY);
                                end else begin
                                    state_q     <= WR_BYTE;
                                    first_arm_q <= 1'b1;
                                end
                            end
                        end
                    end
                    WR_BYTE: begin
                        if (scl_rise && bit_cnt_q != 4'd8) begin
                            shift_q   <= {shift_q[6:0], sda_f};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else if (scl_fall && bit_cnt_q == 4'd8) begin
                            bit_cnt_q   <= 4'd0;
                            wr_data_q   <= shift_q;
                            wr_valid_q  <= 1'b1;
                            wr_first_q  <= first_arm_q;
                            first_arm_q <= 1'b0;
                            sda_oe_q    <= 1'b1;
                            state_q     <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                            state_q  <= WR_BYTE;
                        end
                    end
                    RD_BYTE: begin
                        if (rd_dly_q == 2'd1) begin
                            shift_q  <= rd_data;
                            sda_oe_q <= ~rd_data[7];
                        end else if (scl_fall) begin
                            if (bit_cnt_q == 4'd7) begin
                                bit_cnt_q <= 4'd0;
                                sda_oe_q  <= 1'b0;
                                phase_q   <= 1'b0;
                                state_q   <= RD_ACK;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                shift_q   <= {shift_q[6:0], 1'b0};
                                sda_oe_q  <= ~shift_q[6];
                            end
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise) begin
                            if (sda_f) begin
                                state_q <= IGNORE;
                            end else begin
                                phase_q <= 1'b1;
                            end
                        end else if (scl_fall && phase_q) begin
                            phase_q  <= 1'b0;
                            rd_req_q <= 1'b1;
                            rd_dly_q <= 2'(RD_SAMPLE_DLY);
                            state_q  <= RD_BYTE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_oe    = sda_oe_q;
    assign wr_valid  = wr_valid_q;
    assign wr_data   = wr_data_q;
    assign wr_first  = wr_first_q;
    assign rd_req    = rd_req_q;
    assign busy      = busy_q;
    assign addressed = addressed_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bit-level I2C master driving i2c_target, checked against a transaction-level expectation model.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_target;

    localparam logic [6:0] TGT = 7'h50;
    localparam int         Q   = 25;   // quarter SCL period in CLOCK_50 cycles (500 kHz)

    logic       CLOCK_50;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_line;
    logic       sda_oe;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_first;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       busy;
    logic       addressed;

    int vectors     = 0;
    int miscompares = 0;

    logic [8:0] got_wr[$];
    logic [7:0] rd_q[$];
    int         rd_req_cnt;
    bit         oe_seen;
    logic [7:0] wbuf[4];
    logic [7:0] rbuf[4];

    assign sda_line = sda_m & ~sda_oe;

    i2c_target #(.TARGET_ADDR(TGT), .FILT_LEN(3)) dut (
        .CLOCK_50  (CLOCK_50),
        .rst       (rst),
        .scl_in    (scl_m),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_first  (wr_first),
        .rd_req    (rd_req),
        .rd_data   (rd_data),
        .busy      (busy),
        .addressed (addressed)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // Bus-side observer: collects write strobes, answers read requests, notes any SDA drive.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (wr_valid === 1'b1) got_wr.push_back({wr_first, wr_data});
            if (sda_oe === 1'b1) oe_seen = 1'b1;
            if (rd_req === 1'b1) begin
                rd_req_cnt++;
                if (rd_q.size() > 0) rd_data = rd_q.pop_front();
                else rd_data = 8'hEE;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic m_start();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic m_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic m_rstart();
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(Q);
        scl_m = 1'b0; wait_clk(Q);
    endtask

    // One SCL period; optional 2-cycle low glitch on SCL inside the high phase.
    task automatic m_bit(input logic b, input bit glitch, output logic seen);
        sda_m = b; wait_clk(Q);
        scl_m = 1'b1; wait_clk(Q);
        seen = sda_line;
        if (glitch) begin
            scl_m = 1'b0; wait_clk(2);
            scl_m = 1'b1; wait_clk(Q - 2);
        end else begin
            wait_clk(Q);
        end
        scl_m = 1'b0; wait_clk(Q);
    endtask

    task automatic m_byte(input logic [7:0] b, input int gbit, output bit ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_bit(b[i], (i == gbit), s);
        m_bit(1'b1, 1'b0, s);
        ack = (s == 1'b0);
    endtask

    task automatic m_read(input bit mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, 1'b0, s);
            b[i] = s;
        end
        m_bit(~mack, 1'b0, s);
    endtask

    // Write transaction: matching address ACKs everything and yields one strobe per byte,
    // the first flagged; any other address leaves the bus untouched.
    task automatic txn_write(input string tag, input logic [6:0] a, input int n, input int gbit);
        bit         match;
        bit         ack;
        logic [8:0] exp_wr[$];
        match = (a == TGT);
        got_wr.delete();
        oe_seen = 1'b0;
        m_start();
        chk({tag, "_busy"}, busy, 1'b1);
        m_byte({a, 1'b0}, -1, ack);
        chk({tag, "_aack"}, ack, match);
        chk({tag, "_addressed"}, addressed, match);
        for (int i = 0; i < n; i++) begin
            m_byte(wbuf[i], (i == 0) ? gbit : -1, ack);
            chk($sformatf("%s_dack%0d", tag, i), ack, match);
            if (match) exp_wr.push_back({(i == 0), wbuf[i]});
        end
        m_stop();
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_addr_end"}, addressed, 1'b0);
        chk({tag, "_nwr"}, got_wr.size(), exp_wr.size());
        foreach (exp_wr[i]) begin
            if (i < got_wr.size()) chk($sformatf("%s_wr%0d", tag, i), got_wr[i], exp_wr[i]);
        end
        if (!match) chk({tag, "_oe_seen"}, oe_seen, 1'b0);
    endtask

    // Read transaction: master ACKs all but the last byte; one rd_req per byte delivered.
    task automatic txn_read(input string tag, input logic [6:0] a, input int n);
        bit         match;
        bit         ack;
        logic [7:0] b;
        match = (a == TGT);
        rd_q.delete();
        rd_req_cnt = 0;
        for (int i = 0; i < n; i++) rd_q.push_back(rbuf[i]);
        m_start();
        chk({tag, "_busy"}, busy, 1'b1);
        m_byte({a, 1'b1}, -1, ack);
        chk({tag, "_aack"}, ack, match);
        if (match) begin
            for (int i = 0; i < n; i++) begin
                m_read(i != n - 1, b);
                chk($sformatf("%s_rd%0d", tag, i), b, rbuf[i]);
            end
        end else begin
            m_read(1'b0, b);
            chk({tag, "_rd_idle"}, b, 8'hFF);
        end
        chk({tag, "_oe_after_nack"}, sda_oe, 1'b0);
        m_stop();
        chk({tag, "_nreq"}, rd_req_cnt, match ? n : 0);
        chk({tag, "_busy_end"}, busy, 1'b0);
        chk({tag, "_addr_end"}, addressed, 1'b0);
        rd_q.delete();
    endtask

    initial begin
        bit         ack;
        logic       s;
        logic [7:0] b;
        logic [6:0] a;
        int         n;

        rst        = 1'b1;
        scl_m      = 1'b1;
        sda_m      = 1'b1;
        rd_data    = 8'h00;
        rd_req_cnt = 0;
        oe_seen    = 1'b0;
        wait_clk(3);
        chk("rst_sda_oe", sda_oe, 1'b0);
        chk("rst_wr_valid", wr_valid, 1'b0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_wr_first", wr_first, 1'b0);
        chk("rst_rd_req", rd_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_addressed", addressed, 1'b0);
        rst = 1'b0;
        wait_clk(10);

        // Basic write of two bytes.
        wbuf[0] = 8'h12; wbuf[1] = 8'h34;
        txn_write("wr", TGT, 2, -1);

        // Two-byte read.
        rbuf[0] = 8'h5A; rbuf[1] = 8'hC3;
        txn_read("rd", TGT, 2);

        // Wrong address (0xB0).
        wbuf[0] = 8'hFF;
        txn_write("badaddr", 7'h58, 1, -1);

        // Write then repeated START into a one-byte read.
        got_wr.delete();
        rd_q.delete();
        rd_q.push_back(8'h96);
        rd_req_cnt = 0;
        m_start();
        m_byte({TGT, 1'b0}, -1, ack);
        chk("sr_aack_w", ack, 1'b1);
        m_byte(8'h07, -1, ack);
        chk("sr_dack", ack, 1'b1);
        m_rstart();
        chk("sr_addressed_hold", addressed, 1'b1);
        m_byte({TGT, 1'b1}, -1, ack);
        chk("sr_aack_r", ack, 1'b1);
        chk("sr_addressed_rd", addressed, 1'b1);
        m_read(1'b0, b);
        chk("sr_rd", b, 8'h96);
        m_stop();
        chk("sr_nwr", got_wr.size(), 1);
        if (got_wr.size() > 0) chk("sr_wr0", got_wr[0], {1'b1, 8'h07});
        chk("sr_nreq", rd_req_cnt, 1);

        // SCL glitch inside a data bit must not add a bit.
        wbuf[0] = 8'h3C; wbuf[1] = 8'hA5;
        txn_write("glitch", TGT, 2, 4);

        // Reset in the middle of a data byte.
        got_wr.delete();
        m_start();
        m_byte({TGT, 1'b0}, -1, ack);
        chk("mrst_aack", ack, 1'b1);
        m_bit(1'b1, 1'b0, s);
        m_bit(1'b0, 1'b0, s);
        m_bit(1'b1, 1'b0, s);
        rst = 1'b1;
        #1;
        chk("mrst_sda_oe", sda_oe, 1'b0);
        chk("mrst_wr_valid", wr_valid, 1'b0);
        chk("mrst_wr_data", wr_data, 8'h00);
        chk("mrst_wr_first", wr_first, 1'b0);
        chk("mrst_rd_req", rd_req, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_addressed", addressed, 1'b0);
        wait_clk(1);
        rst = 1'b0;
        sda_m = 1'b1; wait_clk(Q);
        scl_m = 1'b1; wait_clk(2 * Q);
        chk("mrst_nwr", got_wr.size(), 0);
        chk("mrst_idle_busy", busy, 1'b0);
        wbuf[0] = 8'h9C;
        txn_write("postrst", TGT, 1, -1);

        // Randomized transactions against the same expectation model.
        for (int k = 0; k < 6; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = TGT;
            end else begin
                a = 7'($urandom);
                if (a == TGT) a = TGT + 7'd1;
            end
            n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                wbuf[i] = 8'($urandom);
                rbuf[i] = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 1) txn_read($sformatf("rnd%0d_rd", k), a, n);
            else txn_write($sformatf("rnd%0d_wr", k), a, n, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
